// File: rtl/npu_pkg.sv
// Shared definitions for the neuron MAC datapath: FSM encodings,
// default fixed-point format and signed saturation bounds.
package npu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_BIAS   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int DEFAULT_FRAC_BITS = 8;

  // Largest value representable in a signed field of the given width.
  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a signed field of the given width.
  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/neuron_mac_unit_if.sv
// Activation FIFO read port plus result valid/ready port of the MAC unit.
// master = the MAC unit, slave = FIFO / result consumer side.
interface neuron_mac_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_rd_enb;
  logic                  result_valid;
  logic                  result_ready;
  logic [DATA_WIDTH-1:0] result_data;

  modport master (
    input  fifo_rdata, fifo_empty, result_ready,
    output fifo_rd_enb, result_valid, result_data
  );

  modport slave (
    output fifo_rdata, fifo_empty, result_ready,
    input  fifo_rd_enb, result_valid, result_data
  );
endinterface

// File: rtl/sat_relu.sv
// Rescales the accumulator out of the product format, saturates to the
// result width and optionally clamps negative values to zero.
module sat_relu
  import npu_pkg::*;
#(
  parameter int ACC_WIDTH  = 40,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic                         relu_en,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam logic signed [ACC_WIDTH-1:0] R_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] R_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] shifted;

  // Arithmetic shift rounds toward -inf; then clamp to both rails and apply ReLU.
  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > R_MAX) begin
      result = R_MAX[DATA_WIDTH-1:0];
    end else if (shifted < R_MIN) begin
      result = R_MIN[DATA_WIDTH-1:0];
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
    if (relu_en && result[DATA_WIDTH-1]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Neuron evaluation engine: pops NUM_INPUTS activations from the input FIFO,
// multiply-accumulates against local weights, adds bias, rescales/saturates,
// and hands the result out on a valid/ready port. neuron_ready then rewinds
// the FIFO so the same activation vector can be replayed for the next neuron.
//
// state  | meaning
// IDLE   | waiting for start; weight writes accepted here only
// ACCUM  | popping activations and accumulating products
// BIAS   | adding the bias aligned to the product format
// ROUND  | rescale, saturate, ReLU; result registered
// OUTPUT | result_valid held until result_ready
// DONE   | one-cycle neuron_ready pulse
module neuron_mac_unit
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                          clk,
  input  logic                          reset_b,
  input  logic                          start,
  input  logic                          w_wr_en,
  input  logic [$clog2(NUM_INPUTS)-1:0] w_wr_addr,
  input  logic signed [DATA_WIDTH-1:0]  w_wr_data,
  input  logic signed [DATA_WIDTH-1:0]  bias,
  input  logic                          relu_en,
  output logic                          busy,
  output logic                          neuron_ready,
  neuron_mac_unit_if.master             bus
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] weight [NUM_INPUTS];
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic [IDX_W-1:0]             idx_q;
  logic                         pop;

  logic signed [PROD_W-1:0]     act_ext, wgt_ext, prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, bias_ext;
  logic signed [DATA_WIDTH-1:0] sat_out;

  assign act_ext  = PROD_W'($signed(bus.fifo_rdata));
  assign wgt_ext  = PROD_W'(weight[idx_q]);
  assign prod     = act_ext * wgt_ext;
  assign prod_ext = ACC_WIDTH'(prod);
  assign bias_ext = ACC_WIDTH'(bias) <<< FRAC_BITS;

  sat_relu #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_relu (
    .acc    (acc_q),
    .relu_en(relu_en),
    .result (sat_out)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; an empty FIFO simply holds ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACCUM;
      ST_ACCUM:  if (pop && (idx_q == LAST_IDX)) state_d = ST_BIAS;
      ST_BIAS:   state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_OUTPUT;
      ST_OUTPUT: if (bus.result_ready) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; pops only in ACCUM and only when data is present.
  always_comb begin
    pop          = (state_q == ST_ACCUM) && !bus.fifo_empty;
    busy         = (state_q != ST_IDLE);
    neuron_ready = (state_q == ST_DONE);
  end

  assign bus.fifo_rd_enb = pop;

  // Accumulator, index and registered result.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc_q            <= '0;
      idx_q            <= '0;
      bus.result_data  <= '0;
      bus.result_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ST_ACCUM: begin
          if (pop) begin
            acc_q <= acc_q + prod_ext;
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_BIAS: acc_q <= acc_q + bias_ext;
        ST_ROUND: begin
          bus.result_data  <= sat_out;
          bus.result_valid <= 1'b1;
        end
        ST_OUTPUT: if (bus.result_ready) bus.result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Weight store; writes only land while idle so an evaluation sees a fixed set.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_INPUTS; i++) weight[i] <= '0;
    end else if ((state_q == ST_IDLE) && w_wr_en) begin
      weight[w_wr_addr] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Self-checking bench for neuron_mac_unit with a show-ahead FIFO model and
// an arithmetic reference for the neuron result.
module tb_neuron_mac_unit;
  localparam int DW   = 16;
  localparam int N    = 8;
  localparam int FRAC = 8;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic        w_wr_en = 1'b0;
  logic [2:0]  w_wr_addr = '0;
  logic [15:0] w_wr_data = '0;
  logic [15:0] bias = '0;
  logic        relu_en = 1'b0;
  logic        busy;
  logic        neuron_ready;

  logic [15:0] vec [N];
  logic [15:0] wts [N];
  logic [2:0]  rd_ptr = '0;
  int          pop_count = 0;
  int          empty_pops = 0;
  int          nr_count = 0;

  int tests_run = 0;
  int failures  = 0;

  neuron_mac_unit_if #(.DATA_WIDTH(DW)) bus ();

  neuron_mac_unit #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .FRAC_BITS(FRAC), .ACC_WIDTH(40)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .w_wr_en(w_wr_en),
    .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .bias(bias), .relu_en(relu_en),
    .busy(busy), .neuron_ready(neuron_ready), .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_rdata = vec[rd_ptr];

  // FIFO read side: advance on pop, rewind on neuron_ready or reset.
  always @(posedge clk) begin
    if (!reset_b) begin
      rd_ptr = '0;
    end else begin
      if (bus.fifo_rd_enb) begin
        pop_count++;
        if (bus.fifo_empty) empty_pops++;
        rd_ptr = rd_ptr + 3'd1;
      end
      if (neuron_ready) begin
        nr_count++;
        rd_ptr = '0;
      end
    end
  end

  // Reference: exact dot product plus aligned bias, floor-rescale, clamp, ReLU.
  function automatic logic [15:0] model_result(input logic [15:0] b, input logic relu);
    longint total, r;
    total = 0;
    for (int i = 0; i < N; i++)
      total += longint'($signed(vec[i])) * longint'($signed(wts[i]));
    total += longint'($signed(b)) * (longint'(1) << FRAC);
    r = total >>> FRAC;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return 16'(r);
  endfunction

  task automatic load_weights();
    for (int i = 0; i < N; i++) begin
      w_wr_en = 1'b1; w_wr_addr = 3'(i); w_wr_data = wts[i];
      @(posedge clk); #1;
    end
    w_wr_en = 1'b0;
  endtask

  // One evaluation with an always-full FIFO; lat counts edges from the start edge.
  task automatic run_eval(output logic [15:0] res, output int lat, output int pops,
                          output logic nr_done, output logic valid_done, output logic nr_idle);
    int p0;
    p0 = pop_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin lat = n; break; end
    end
    res = bus.result_data;
    pops = pop_count - p0;
    nr_done = 1'b0; valid_done = 1'b1; nr_idle = 1'b1;
    if (lat > 0) begin
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      nr_done = neuron_ready; valid_done = bus.result_valid;
      bus.result_ready = 1'b0;
      @(posedge clk); #1;
      nr_idle = neuron_ready;
    end
  endtask

  task automatic test_reset();
    tests_run++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.result_valid); end
    tests_run++; if (bus.result_data !== 16'h0) begin failures++; $display("FAIL reset_data got %h want 0000", bus.result_data); end
    tests_run++; if (bus.fifo_rd_enb !== 1'b0) begin failures++; $display("FAIL reset_rd_enb got %b want 0", bus.fifo_rd_enb); end
    tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (neuron_ready !== 1'b0) begin failures++; $display("FAIL reset_nready got %b want 0", neuron_ready); end
  endtask

  task automatic test_ramp();
    logic [15:0] res; int lat, pops; logic nd, vd, ni;
    for (int i = 0; i < N; i++) begin wts[i] = 16'h0100; vec[i] = 16'((i + 1) * 256); end
    bias = 16'h0; relu_en = 1'b0;
    load_weights();
    run_eval(res, lat, pops, nd, vd, ni);
    tests_run++; if (res !== 16'h2400) begin failures++; $display("FAIL ramp_data got %h want 2400", res); end
    tests_run++; if (res !== model_result(bias, relu_en)) begin failures++; $display("FAIL ramp_model got %h want %h", res, model_result(bias, relu_en)); end
    tests_run++; if (lat !== N + 2) begin failures++; $display("FAIL ramp_latency got %0d edges want %0d", lat, N + 2); end
    tests_run++; if (pops !== N) begin failures++; $display("FAIL ramp_pops got %0d want %0d", pops, N); end
    tests_run++; if (nd !== 1'b1 || vd !== 1'b0) begin failures++; $display("FAIL ramp_handshake got nready=%b valid=%b want 1/0", nd, vd); end
    tests_run++; if (ni !== 1'b0) begin failures++; $display("FAIL ramp_nready_width got %b want 0", ni); end
  endtask

  task automatic test_negative();
    logic [15:0] res; int lat, pops; logic nd, vd, ni;
    for (int i = 0; i < N; i++) begin wts[i] = 16'hFF00; vec[i] = 16'h0100; end
    bias = 16'h0;
    load_weights();
    relu_en = 1'b0;
    run_eval(res, lat, pops, nd, vd, ni);
    tests_run++; if (res !== 16'hF800) begin failures++; $display("FAIL neg_norelu got %h want f800", res); end
    relu_en = 1'b1;
    run_eval(res, lat, pops, nd, vd, ni);
    tests_run++; if (res !== 16'h0000) begin failures++; $display("FAIL neg_relu got %h want 0000", res); end
    relu_en = 1'b0;
  endtask

  task automatic test_saturation();
    logic [15:0] res; int lat, pops; logic nd, vd, ni;
    for (int i = 0; i < N; i++) begin wts[i] = 16'h7FFF; vec[i] = 16'h7FFF; end
    bias = 16'h7FFF;
    load_weights();
    run_eval(res, lat, pops, nd, vd, ni);
    tests_run++; if (res !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got %h want 7fff", res); end
    for (int i = 0; i < N; i++) wts[i] = 16'h8000;
    bias = 16'h0;
    load_weights();
    run_eval(res, lat, pops, nd, vd, ni);
    tests_run++; if (res !== 16'h8000) begin failures++; $display("FAIL sat_neg got %h want 8000", res); end
  endtask

  task automatic test_stall_busy();
    logic [15:0] ref_res, res, exp; int lat, pops, p0, e0; logic nd, vd, ni;
    for (int i = 0; i < N; i++) begin wts[i] = 16'($urandom); vec[i] = 16'($urandom); end
    bias = 16'($urandom); relu_en = 1'b0;
    load_weights();
    exp = model_result(bias, relu_en);
    run_eval(ref_res, lat, pops, nd, vd, ni);
    p0 = pop_count; e0 = empty_pops;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      bus.fifo_empty = n[0];
      w_wr_en = 1'($urandom); w_wr_addr = 3'($urandom); w_wr_data = 16'($urandom);
      start = 1'($urandom);
      @(posedge clk); #1;
      if (bus.result_valid) begin lat = n; break; end
    end
    w_wr_en = 1'b0; start = 1'b0; bus.fifo_empty = 1'b0;
    res = bus.result_data;
    tests_run++; if (lat < 0) begin failures++; $display("FAIL stall_timeout got no result_valid want valid"); end
    tests_run++; if (pop_count - p0 !== N) begin failures++; $display("FAIL stall_pops got %0d want %0d", pop_count - p0, N); end
    tests_run++; if (empty_pops !== e0) begin failures++; $display("FAIL stall_pop_while_empty got %0d want 0", empty_pops - e0); end
    tests_run++; if (res !== exp || res !== ref_res) begin failures++; $display("FAIL stall_result got %h want %h", res, exp); end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    @(posedge clk); #1;
    run_eval(res, lat, pops, nd, vd, ni);
    tests_run++; if (res !== exp) begin failures++; $display("FAIL stall_weights_kept got %h want %h", res, exp); end
  endtask

  task automatic test_hold();
    logic [15:0] held, exp; int lat; int bad;
    for (int i = 0; i < N; i++) vec[i] = 16'($urandom);
    bias = 16'($urandom); relu_en = 1'b1;
    exp = model_result(bias, relu_en);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin lat = n; break; end
    end
    held = bus.result_data;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.result_valid !== 1'b1 || bus.result_data !== held || neuron_ready !== 1'b0) bad++;
    end
    tests_run++; if (lat < 0 || held !== exp) begin failures++; $display("FAIL hold_result got %h want %h", held, exp); end
    tests_run++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    tests_run++; if (neuron_ready !== 1'b1) begin failures++; $display("FAIL hold_nready got %b want 1", neuron_ready); end
    @(posedge clk); #1;
    tests_run++; if (neuron_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_done got nready=%b busy=%b want 0/0", neuron_ready, busy); end
    relu_en = 1'b0;
  endtask

  task automatic test_write_with_start();
    logic [15:0] res, exp; int lat, pops; logic nd, vd, ni;
    wts[2] = 16'($urandom);
    bias = 16'($urandom);
    exp = model_result(bias, relu_en);
    w_wr_en = 1'b1; w_wr_addr = 3'd2; w_wr_data = wts[2];
    run_eval(res, lat, pops, nd, vd, ni);
    w_wr_en = 1'b0;
    tests_run++; if (res !== exp) begin failures++; $display("FAIL write_with_start got %h want %h", res, exp); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] res; int lat, pops, p0, nr0; logic nd, vd, ni; logic seen;
    for (int i = 0; i < N; i++) vec[i] = 16'h7FFF;
    p0 = pop_count; nr0 = nr_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (pop_count - p0 >= 3) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests_run++; if (seen !== 1'b1) begin failures++; $display("FAIL abort_three_pops got %0d pops want 3", pop_count - p0); end
    reset_b = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || bus.fifo_rd_enb !== 1'b0 || bus.result_valid !== 1'b0 || bus.result_data !== 16'h0)
      begin failures++; $display("FAIL abort_outputs got busy=%b rd=%b valid=%b data=%h want all 0", busy, bus.fifo_rd_enb, bus.result_valid, bus.result_data); end
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (nr_count !== nr0) begin failures++; $display("FAIL abort_nready got %0d pulses want 0", nr_count - nr0); end
    for (int i = 0; i < N; i++) begin wts[i] = 16'($urandom); vec[i] = 16'($urandom); end
    bias = 16'($urandom);
    load_weights();
    run_eval(res, lat, pops, nd, vd, ni);
    tests_run++; if (res !== model_result(bias, relu_en)) begin failures++; $display("FAIL abort_fresh_result got %h want %h", res, model_result(bias, relu_en)); end
  endtask

  task automatic test_random();
    logic [15:0] res, exp; int lat, pops; logic nd, vd, ni;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin
        wts[i] = (t < 3) ? 16'($signed(10'($urandom))) : 16'($urandom);
        vec[i] = 16'($urandom);
      end
      bias = 16'($urandom); relu_en = 1'($urandom);
      load_weights();
      exp = model_result(bias, relu_en);
      run_eval(res, lat, pops, nd, vd, ni);
      tests_run++; if (res !== exp || pops !== N) begin failures++; $display("FAIL random_%0d got %h pops=%0d want %h pops=%0d", t, res, pops, exp, N); end
    end
    relu_en = 1'b0;
  endtask

  initial begin
    bus.fifo_empty = 1'b0;
    bus.result_ready = 1'b0;
    for (int i = 0; i < N; i++) begin vec[i] = '0; wts[i] = '0; end
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_ramp();
    test_negative();
    test_saturation();
    test_stall_busy();
    test_hold();
    test_write_with_start();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
